// File: rtl/encoder_input_pkg.sv
// ============================================================================
//  Module      : encoder_pkg
//  Description : Shared constants for the front-panel input peripheral:
//                register offsets, STATUS/EVENTS bit indices and the
//                quadrature decoder step encoding.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package encoder_pkg;

  // Word offsets inside the peripheral window
  localparam logic [1:0] c_reg_status   = 2'd0;
  localparam logic [1:0] c_reg_position = 2'd1;
  localparam logic [1:0] c_reg_events   = 2'd2;
  localparam logic [1:0] c_reg_ctrl     = 2'd3;

  // STATUS layout: debounced levels in [2:0], EVENTS mirrored from bit 3 up
  localparam int c_st_bak    = 0;
  localparam int c_st_psh    = 1;
  localparam int c_st_con    = 2;
  localparam int c_st_ev_lsb = 3;

  // EVENTS bit indices (also the irq mask layout)
  localparam int c_ev_bak   = 0;
  localparam int c_ev_psh   = 1;
  localparam int c_ev_con   = 2;
  localparam int c_ev_moved = 3;
  localparam int c_ev_err   = 4;
  localparam int c_ev_bits  = 5;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  // Forward successor in the Gray ring 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] gray_next(input logic [1:0] s);
    return {s[0], ~s[1]};
  endfunction

  // x4 quadrature decode of one {A,B} sample against the previous one
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)                 return STEP_NONE;
    else if (cur == gray_next(prev)) return STEP_INC;
    else if (prev == gray_next(cur)) return STEP_DEC;
    else                             return STEP_ERR;
  endfunction

endpackage

`default_nettype wire

// File: rtl/encoder_input_if.sv
// ============================================================================
//  Module      : encoder_input_if
//  Description : Word-addressed CPU slave bus (select/ready handshake).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface encoder_input_if;
  logic        sel;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (output sel, addr, wdata, wstrb, input  rdata, ready);
  modport slave  (input  sel, addr, wdata, wstrb, output rdata, ready);
endinterface

`default_nettype wire

// File: rtl/encoder_input_debounce.sv
// ============================================================================
//  Module      : debounce
//  Description : Active-low button conditioner: synchroniser, stability
//                filter counter and a one-cycle pulse on a debounced
//                1 -> 0 transition (press).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  logic [SYNC_STAGES-1:0]   r_sync;
  logic [DEBOUNCE_BITS-1:0] r_count;
  logic                     r_level;
  logic                     r_level_q;
  logic                     w_in;

  assign w_in = r_sync[SYNC_STAGES-1];

  // Synchroniser chain, idles at "released"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '1;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
  end

  // Filter: count while the input disagrees with the accepted level; any
  // bounce back to the accepted level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_level <= 1'b1;
    end else if (w_in == r_level) begin
      r_count <= '0;
    end else if (&r_count) begin
      r_level <= w_in;
      r_count <= '0;
    end else begin
      r_count <= r_count + DEBOUNCE_BITS'(1);
    end
  end

  // Delayed level for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_level_q <= 1'b1;
    else        r_level_q <= r_level;
  end

  assign level = r_level;
  assign press = r_level_q & ~r_level;

endmodule

`default_nettype wire

// File: rtl/encoder_input.sv
// ============================================================================
//  Module      : encoder_input
//  Description : Front-panel input peripheral: rotary encoder position
//                counter plus three debounced buttons with sticky press
//                events, on a word-addressed CPU slave bus.
//                Optional feature macro ENCODER_IRQ_EN: CTRL irq mask and a
//                registered level interrupt; without it irq is tied low and
//                CTRL reads as zero.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module encoder_input
  import encoder_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 16,
  parameter int COUNT_BITS    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  encoder_input_if.slave  bus,
  input  logic            tra,
  input  logic            trb,
  input  logic            con_button,
  input  logic            psh_button,
  input  logic            bak_button,
  output logic            irq
);

  // ---------------- buttons ----------------
  logic [2:0] w_lvl;    // {con, psh, bak}
  logic [2:0] w_press;  // {con, psh, bak}

  debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_BITS(DEBOUNCE_BITS)) u_bak (
    .clk(clk), .rst_n(rst_n), .raw(bak_button), .level(w_lvl[0]), .press(w_press[0]));
  debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_BITS(DEBOUNCE_BITS)) u_psh (
    .clk(clk), .rst_n(rst_n), .raw(psh_button), .level(w_lvl[1]), .press(w_press[1]));
  debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_BITS(DEBOUNCE_BITS)) u_con (
    .clk(clk), .rst_n(rst_n), .raw(con_button), .level(w_lvl[2]), .press(w_press[2]));

  // ---------------- encoder ----------------
  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [SYNC_STAGES:0]   r_enc_fill;
  logic [1:0]             r_enc_prev;
  logic [1:0]             w_enc_cur;
  logic                   w_enc_live;
  step_t                  w_step;

  assign w_enc_cur  = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
  // Decoding starts only once the synchronisers hold real pin samples, so
  // their reset value can never be mistaken for a rotation
  assign w_enc_live = r_enc_fill[SYNC_STAGES];
  assign w_step     = w_enc_live ? decode_step(r_enc_prev, w_enc_cur) : STEP_NONE;

  // Phase synchronisers, fill tracker and previous-sample register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_a   <= '1;
      r_sync_b   <= '1;
      r_enc_fill <= '0;
      r_enc_prev <= 2'b11;
    end else begin
      r_sync_a   <= {r_sync_a[SYNC_STAGES-2:0], tra};
      r_sync_b   <= {r_sync_b[SYNC_STAGES-2:0], trb};
      r_enc_fill <= {r_enc_fill[SYNC_STAGES-1:0], 1'b1};
      r_enc_prev <= w_enc_cur;
    end
  end

  // ---------------- bus decode ----------------
  logic                  r_ready;
  logic [31:0]           r_rdata;
  logic [31:0]           w_rd_mux;
  logic                  w_access;
  logic                  w_write;
  logic                  w_pos_wr;
  logic [c_ev_bits-1:0]  w_ev_clr;
  logic [c_ev_bits-1:0]  w_ev_set;
  logic [c_ev_bits-1:0]  r_events;
  logic [c_ev_bits-1:0]  w_mask;
  logic [COUNT_BITS-1:0] r_position;
  logic [31:0]           w_pos_ext;
  logic                  w_unused;

  assign w_access  = bus.sel & ~r_ready;
  assign w_write   = w_access & (|bus.wstrb);
  assign w_pos_wr  = w_write & (bus.addr == c_reg_position);
  assign w_ev_clr  = (w_write && bus.addr == c_reg_events) ? bus.wdata[c_ev_bits-1:0] : '0;
  assign w_pos_ext = 32'($signed(r_position));
  assign w_unused  = ^bus.wdata;

  // A position write takes priority, so a coincident encoder step is lost
  // and does not count as movement
  assign w_ev_set = {(w_step == STEP_ERR),
                     (w_step == STEP_INC || w_step == STEP_DEC) & ~w_pos_wr,
                     w_press};

  // Position counter, wraps modulo 2^COUNT_BITS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_position <= '0;
    else if (w_pos_wr)          r_position <= bus.wdata[COUNT_BITS-1:0];
    else if (w_step == STEP_INC) r_position <= r_position + COUNT_BITS'(1);
    else if (w_step == STEP_DEC) r_position <= r_position - COUNT_BITS'(1);
  end

  // Sticky events: new events win over a same-cycle W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_events <= '0;
    else        r_events <= (r_events & ~w_ev_clr) | w_ev_set;
  end

  // Register read multiplexer
  always_comb begin
    w_rd_mux = '0;
    case (bus.addr)
      c_reg_status:   w_rd_mux = {24'b0, r_events, w_lvl};
      c_reg_position: w_rd_mux = w_pos_ext;
      c_reg_events:   w_rd_mux = {27'b0, r_events};
      default:        w_rd_mux = {27'b0, w_mask};
    endcase
  end

  // One ready pulse per access, read data captured at the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_access;
      r_rdata <= (w_access && !(|bus.wstrb)) ? w_rd_mux : '0;
    end
  end

  assign bus.ready = r_ready;
  assign bus.rdata = r_rdata;

  // ---------------- interrupt ----------------
`ifdef ENCODER_IRQ_EN
  logic [c_ev_bits-1:0] r_mask;
  logic                 r_irq;

  // CTRL mask register and registered level interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_write && bus.addr == c_reg_ctrl) r_mask <= bus.wdata[c_ev_bits-1:0];
      r_irq <= |(r_events & r_mask);
    end
  end

  assign w_mask = r_mask;
  assign irq    = r_irq;
`else
  assign w_mask = '0;
  assign irq    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_encoder_input.sv
// ============================================================================
//  Module      : tb_encoder_input
//  Description : Self-checking bench for encoder_input (DEBOUNCE_BITS=4,
//                COUNT_BITS=8, SYNC_STAGES=2): a vector table for the
//                encoder/register path plus hand-timed sequences for
//                latency, priority, debounce, irq and reset corners.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_encoder_input;
  import encoder_pkg::*;

`ifdef ENCODER_IRQ_EN
  localparam logic [31:0] c_exp_irq  = 32'd1;
  localparam logic [31:0] c_exp_ctrl = 32'h02;
`else
  localparam logic [31:0] c_exp_irq  = 32'd0;
  localparam logic [31:0] c_exp_ctrl = 32'h00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tra = 1'b0, trb = 1'b0;
  logic con_button = 1'b1, psh_button = 1'b1, bak_button = 1'b1;
  logic irq;

  int n_checks = 0;
  int n_errors = 0;

  encoder_input_if bus ();

  encoder_input #(.SYNC_STAGES(2), .DEBOUNCE_BITS(4), .COUNT_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .tra(tra), .trb(trb),
    .con_button(con_button), .psh_button(psh_button), .bak_button(bak_button),
    .irq(irq));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  typedef enum int {OP_ENC, OP_WR, OP_RD} op_t;
  typedef struct {
    op_t         op;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void add(input op_t op, input logic [1:0] a, input logic [31:0] d,
                              input logic [31:0] e, input string n);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.exp = e; v.name = n;
    tbl.push_back(v);
  endfunction

  // Called at a falling edge; returns two falling edges later (one idle
  // cycle so that back-to-back accesses each get their own ready pulse)
  task automatic bus_access(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd, output logic irq_ack);
    bus.sel = 1'b1; bus.addr = a; bus.wdata = d; bus.wstrb = s;
    @(negedge clk);
    check("ready", {31'b0, bus.ready}, 32'd1);
    rd      = bus.rdata;
    irq_ack = irq;
    bus.sel = 1'b0; bus.wstrb = 4'h0; bus.wdata = '0;
    @(negedge clk);
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] e, input string n);
    logic [31:0] rd;
    logic        ia;
    bus_access(a, 32'h0, 4'h0, rd, ia);
    check(n, rd, e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        ia;
    bus_access(a, d, 4'hF, rd, ia);
  endtask

  task automatic set_enc(input logic [1:0] ab);
    tra = ab[1]; trb = ab[0];
  endtask

  initial begin
    logic [1:0]  gray [4];
    logic [31:0] rd;
    logic        ia;
    int          j;

    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
    bus.sel = 1'b0; bus.addr = 2'd0; bus.wdata = '0; bus.wstrb = 4'h0;

    // ---- vector table ----
    j = 0;
    for (int k = 0; k < 16; k++) begin j = (j + 1) % 4; add(OP_ENC, 2'd0, {30'b0, gray[j]}, 32'h0, "fwd"); end
    add(OP_RD, c_reg_position, 0, 32'h0000_0010, "pos_fwd16");
    add(OP_RD, c_reg_status,   0, 32'h0000_0047, "status_moved");
    for (int k = 0; k < 17; k++) begin j = (j + 3) % 4; add(OP_ENC, 2'd0, {30'b0, gray[j]}, 32'h0, "rev"); end
    add(OP_RD, c_reg_position, 0, 32'hFFFF_FFFF, "pos_rev17");
    add(OP_WR, c_reg_events,   32'h1F, 0, "clr_all");
    add(OP_RD, c_reg_events,   0, 32'h0, "events_cleared");
    add(OP_WR, c_reg_position, 32'h7F, 0, "load_7f");
    add(OP_RD, c_reg_position, 0, 32'h0000_007F, "pos_load");
    j = (j + 1) % 4; add(OP_ENC, 2'd0, {30'b0, gray[j]}, 32'h0, "fwd_wrap");
    add(OP_RD, c_reg_position, 0, 32'hFFFF_FF80, "pos_wrap");
    add(OP_ENC, 2'd0, 32'h3, 32'h0, "both_change");
    add(OP_RD, c_reg_position, 0, 32'hFFFF_FF80, "pos_err_nocount");
    add(OP_RD, c_reg_status,   0, 32'h0000_00C7, "status_err");
    add(OP_WR, c_reg_events,   32'h10, 0, "w1c_err");
    add(OP_RD, c_reg_status,   0, 32'h0000_0047, "status_err_cleared");
    add(OP_RD, c_reg_events,   0, 32'h08, "events_read1");
    add(OP_RD, c_reg_events,   0, 32'h08, "events_read2_nondestructive");
    add(OP_WR, c_reg_events,   32'h08, 0, "w1c_moved");
    add(OP_RD, c_reg_events,   0, 32'h0, "events_empty");

    // ---- reset ----
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, bus.ready}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_irq",   {31'b0, irq}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rd_chk(c_reg_status,   32'h07, "init_status");
    rd_chk(c_reg_position, 32'h00, "init_position");
    rd_chk(c_reg_ctrl,     32'h00, "init_ctrl");

    // ---- table ----
    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_ENC: begin set_enc(tbl[i].data[1:0]); repeat (4) @(negedge clk); end
        OP_WR:  wr(tbl[i].addr, tbl[i].data);
        default: rd_chk(tbl[i].addr, tbl[i].exp, tbl[i].name);
      endcase
    end

    // ---- encoder latency: phases 11 -> 10 is +1, visible 3 edges later ----
    set_enc(2'b10);
    repeat (2) @(negedge clk);
    rd_chk(c_reg_position, 32'hFFFF_FF80, "pos_latency_before");
    rd_chk(c_reg_position, 32'hFFFF_FF81, "pos_latency_after");
    wr(c_reg_events, 32'h1F);

    // ---- POSITION write and step on the same edge: write wins ----
    set_enc(2'b00);
    repeat (2) @(negedge clk);
    wr(c_reg_position, 32'h55);
    rd_chk(c_reg_position, 32'h0000_0055, "pos_write_wins");
    wr(c_reg_events, 32'h1F);

    // ---- event set and W1C on the same edge: set wins ----
    set_enc(2'b01);
    repeat (2) @(negedge clk);
    wr(c_reg_events, 32'h08);
    rd_chk(c_reg_events,   32'h08, "event_set_wins");
    rd_chk(c_reg_position, 32'h0000_0056, "pos_after_step");
    wr(c_reg_events, 32'h1F);

    // ---- debounce with bounce, then a stable press ----
    wr(c_reg_ctrl, 32'h02);
    rd_chk(c_reg_ctrl, c_exp_ctrl, "ctrl_readback");
    for (int t = 0; t < 12; t++) begin
      psh_button = ~psh_button;
      repeat (5) @(negedge clk);
    end
    psh_button = 1'b0;                       // final edge
    repeat (18) @(negedge clk);
    check("irq_before_event", {31'b0, irq}, 32'd0);
    bus_access(c_reg_events, 32'h0, 4'h0, rd, ia);   // sampled at edge 19
    check("psh_event_not_yet", rd, 32'h0);
    check("irq_at_event_edge", {31'b0, ia}, 32'd0);
    check("irq_after_event", {31'b0, irq}, c_exp_irq);
    rd_chk(c_reg_events, 32'h02, "psh_event_set");
    bus_access(c_reg_events, 32'h02, 4'hF, rd, ia);  // W1C commits at ack edge
    check("irq_held_at_w1c", {31'b0, ia}, c_exp_irq);
    check("irq_cleared", {31'b0, irq}, 32'd0);
    repeat (30) @(negedge clk);
    rd_chk(c_reg_events, 32'h00, "psh_single_event");
    rd_chk(c_reg_status, 32'h05, "psh_level_low");
    psh_button = 1'b1;
    repeat (25) @(negedge clk);
    rd_chk(c_reg_status, 32'h07, "psh_release_no_event");

    // ---- reset mid-debounce and mid-rotation ----
    psh_button = 1'b0;
    repeat (8) @(negedge clk);
    set_enc(2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2_ready", {31'b0, bus.ready}, 32'd0);
    check("rst2_rdata", bus.rdata, 32'd0);
    check("rst2_irq",   {31'b0, irq}, 32'd0);
    psh_button = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd_chk(c_reg_status, 32'h07, "rst2_status_immediate");
    repeat (10) @(negedge clk);
    rd_chk(c_reg_position, 32'h00, "rst2_position");
    rd_chk(c_reg_status,   32'h07, "rst2_status_no_count");
    rd_chk(c_reg_ctrl,     32'h00, "rst2_ctrl");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
